// File: rtl/code_lock_ctrl.sv
// Keypad code-entry lock controller: 4-digit compare, retry/alarm sequencing, blink and unlock outputs.
// Outputs are registered one edge after the sampled key; keys outside IDLE/ENTRY are dropped, no backpressure.
module code_lock_ctrl #(
  parameter logic [15:0] CODE          = 16'h1234,
  parameter int          MAX_TRIES     = 3,
  parameter int          UNLOCK_CYCLES = 50000000,
  parameter int          FAIL_CYCLES   = 25000000,
  parameter int          ALARM_CYCLES  = 250000000,
  parameter int          BLINK_DIV     = 6250000,
  parameter int          ENTRY_TIMEOUT = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  output logic [2:0] command,
  output logic       blink,
  output logic       unlocked
);

  localparam int TM_A = (UNLOCK_CYCLES > FAIL_CYCLES) ? UNLOCK_CYCLES : FAIL_CYCLES;
  localparam int TM_B = (ALARM_CYCLES > ENTRY_TIMEOUT) ? ALARM_CYCLES : ENTRY_TIMEOUT;
  localparam int TMAX = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(BLINK_DIV + 1);
  localparam int FW   = $clog2(MAX_TRIES + 1);

  localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] FAIL_LAST   = TW'(FAIL_CYCLES - 1);
  localparam logic [TW-1:0] ALARM_LAST  = TW'(ALARM_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(BLINK_DIV - 1);
  localparam logic [FW-1:0] TRY_LAST    = FW'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_OPEN  = 3'd3,
    S_FAIL  = 3'd4,
    S_ALARM = 3'd5,
    S_CLR   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   entry_q, entry_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic          blink_q, blink_d;
  logic [2:0]    command_q, command_d;
  logic          unlocked_q, unlocked_d;
  logic          key_digit, key_cancel;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    timer_d    = timer_q + TW'(1);
    div_d      = '0;
    blink_d    = 1'b1;
    command_d  = 3'b000;
    unlocked_d = 1'b0;
    key_digit  = key_valid && (key_val <= 4'd9);
    key_cancel = key_valid && (key_val == 4'hA);

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        if (key_digit) begin
          entry_d = {12'h000, key_val};
          cnt_d   = 3'd1;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // A key arriving on the timeout edge takes priority over the timeout.
        if (key_cancel) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (key_digit) begin
          entry_d = {entry_q[11:0], key_val};
          cnt_d   = cnt_q + 3'd1;
          timer_d = '0;
          if (cnt_q == 3'd3) state_d = S_CHECK;
        end else if (timer_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (entry_q == CODE) begin
          fail_d  = '0;
          state_d = S_OPEN;
        end else begin
          fail_d  = fail_q + FW'(1);
          state_d = (fail_q >= TRY_LAST) ? S_ALARM : S_FAIL;
        end
      end
      S_OPEN:  if (timer_q == UNLOCK_LAST) state_d = S_IDLE;
      S_FAIL:  if (timer_q == FAIL_LAST)   state_d = S_IDLE;
      S_ALARM: if (timer_q == ALARM_LAST)  state_d = S_CLR;
      S_CLR: begin
        fail_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    // Divider runs only while staying in a blinking state; entry edge restarts it.
    if ((state_d == S_FAIL || state_d == S_ALARM) && state_d == state_q) begin
      if (div_q == DIV_LAST) begin
        blink_d = ~blink_q;
      end else begin
        div_d   = div_q + DW'(1);
        blink_d = blink_q;
      end
    end

    case (state_d)
      S_ENTRY: command_d = cnt_d;
      S_CHECK, S_OPEN, S_FAIL: command_d = 3'b100;
      S_ALARM: command_d = 3'b101;
      S_CLR:   command_d = 3'b110;
      default: command_d = 3'b000;
    endcase
    unlocked_d = (state_d == S_OPEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
      div_q      <= '0;
      blink_q    <= 1'b1;
      command_q  <= 3'b000;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      blink_q    <= blink_d;
      command_q  <= command_d;
      unlocked_q <= unlocked_d;
    end
  end

  assign command  = command_q;
  assign blink    = blink_q;
  assign unlocked = unlocked_q;

endmodule
